// File: rtl/redmule_z_buffer_pp_pkg.sv
// redmule_z_buffer_pp_pkg: shared types and constants for the multi-bank Z/Y accumulator buffer
// No ports. Provides the element format enum, bank state enum, control/flag structs and defaults.
package redmule_z_buffer_pp_pkg;
    typedef enum logic [1:0] {FP32, FP16, FP8, FP16ALT} fp_format_e;
    localparam int unsigned ARRAY_WIDTH = 4;
    localparam int unsigned ZBUF_NB_DEFAULT = 2;
    typedef enum logic [1:0] {BANK_FREE, BANK_LOADED, BANK_FILLING, BANK_FULL} bank_state_e;
    typedef struct packed {
        logic fill;
        logic y_valid;
        logic ready;
        logic y_push_enable;
        logic y_bypass;
        logic first_load;
        logic [15:0] y_width;
        logic [15:0] y_height;
        logic [15:0] z_width;
        logic [15:0] z_height;
    } z_buffer_pp_ctrl_t;
    typedef struct packed {
        logic y_ready;
        logic z_valid;
        logic z_priority;
        logic y_pushed;
        logic loaded;
        logic empty;
        logic fill_ready;
        logic [7:0] free_banks;
    } z_buffer_pp_flgs_t;
    function automatic int unsigned fp_width(fp_format_e f);
        return f == FP32 ? 32 : f == FP8 ? 8 : 16;
    endfunction
endpackage

// File: rtl/redmule_z_buffer_bank.sv
// redmule_z_buffer_bank: one D x W latch-free register bank with row and column write/read ports
// Ports: clk_i clock; row_we/row_waddr/row_wdata write one W-element row; row_raddr/row_rdata read one row;
//        col_we/col_waddr/col_wdata write one D-element column; col_raddr/col_rdata read one column.
module redmule_z_buffer_bank #(
    parameter int unsigned D    = 18,
    parameter int unsigned W    = 4,
    parameter int unsigned BITW = 16
) (
    input  logic                   clk_i,
    input  logic                   row_we,
    input  logic [$clog2(D)-1:0]   row_waddr,
    input  logic [W*BITW-1:0]      row_wdata,
    input  logic [$clog2(D)-1:0]   row_raddr,
    output logic [W*BITW-1:0]      row_rdata,
    input  logic                   col_we,
    input  logic [$clog2(W)-1:0]   col_waddr,
    input  logic [D*BITW-1:0]      col_wdata,
    input  logic [$clog2(W)-1:0]   col_raddr,
    output logic [D*BITW-1:0]      col_rdata
);
    logic [BITW-1:0] mem [D][W];
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < W; w++) if (row_we) mem[row_waddr][w] <= row_wdata[w*BITW +: BITW];
        for (int d = 0; d < D; d++) if (col_we) mem[d][col_waddr] <= col_wdata[d*BITW +: BITW];
    end
    for (genvar w = 0; w < W; w++) begin : g_row
        assign row_rdata[w*BITW +: BITW] = mem[row_raddr][w];
    end
    for (genvar d = 0; d < D; d++) begin : g_col
        assign col_rdata[d*BITW +: BITW] = mem[d][col_raddr];
    end
endmodule

// File: rtl/redmule_z_buffer_pp.sv
// redmule_z_buffer_pp: NB-bank ping-pong Z/Y buffer overlapping bias load, push/fill and Z store-out
// Ports: clk_i, rst_ni (async active-low), clear_i (sync clear); ctrl_i control struct; z_buffer_i array row in;
//        y_buffer_i bias column in; z_buffer_o Z column out; y_buffer_o bias row out; z_strb_o byte strobes;
//        flags_o status struct; perf_o (3x32: fill stalls, store cycles, bypass banks) only with
//        REDMULE_ZBUF_PERF_CNT_EN defined.
module redmule_z_buffer_pp
    import redmule_z_buffer_pp_pkg::*;
#(
    parameter int unsigned DW       = 288,
    parameter fp_format_e  FpFormat = FP16,
    parameter int unsigned Width    = ARRAY_WIDTH,
    parameter int unsigned NB       = ZBUF_NB_DEFAULT
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               clear_i,
    input  z_buffer_pp_ctrl_t                  ctrl_i,
    input  logic [Width*fp_width(FpFormat)-1:0] z_buffer_i,
    input  logic [DW-1:0]                      y_buffer_i,
    output logic [DW-1:0]                      z_buffer_o,
    output logic [Width*fp_width(FpFormat)-1:0] y_buffer_o,
    output logic [DW/8-1:0]                    z_strb_o,
    output z_buffer_pp_flgs_t                  flags_o
`ifdef REDMULE_ZBUF_PERF_CNT_EN
    ,
    output logic [2:0][31:0]                   perf_o
`endif
);
    localparam int unsigned BITW = fp_width(FpFormat);
    localparam int unsigned W = Width;
    localparam int unsigned D = DW / BITW;
    localparam int unsigned DA = $clog2(D);
    localparam int unsigned WA = $clog2(W);
    localparam int unsigned PA = $clog2(NB);
    bank_state_e state_q [NB];
    bank_state_e state_d [NB];
    logic [NB-1:0] byp_q;
    logic [PA-1:0] ld_ptr_q, push_ptr_q, st_ptr_q;
    logic [WA-1:0] w_idx_q, st_idx_q;
    logic [DA-1:0] d_idx_q, fill_idx_q;
    logic [W*BITW-1:0] y_buf_q;
    logic [DW-1:0] z_buf_q;
    logic [W*BITW-1:0] row_rdata [NB];
    logic [DW-1:0] col_rdata [NB];
    logic y_ready, ld_beat, ld_done, byp_ld, push, push_wrap, fill_ready, fill_we, fill_done, z_valid, st_done;
    assign y_ready    = state_q[ld_ptr_q] == BANK_FREE && !ctrl_i.y_bypass && !(ld_ptr_q == push_ptr_q && d_idx_q != '0);
    assign ld_beat    = ctrl_i.y_valid && y_ready;
    assign ld_done    = ld_beat && 16'(w_idx_q) == ctrl_i.y_width - 16'd1;
    assign byp_ld     = ctrl_i.y_bypass && state_q[ld_ptr_q] == BANK_FREE;
    assign push       = ctrl_i.y_push_enable && state_q[push_ptr_q] == BANK_LOADED;
    assign push_wrap  = push && 16'(d_idx_q) == ctrl_i.y_height - 16'd1;
    assign fill_ready = state_q[push_ptr_q] inside {BANK_LOADED, BANK_FILLING};
    // a fill without fill_ready is dropped here and flagged by the assertion below
    assign fill_we    = ctrl_i.fill && fill_ready;
    assign fill_done  = fill_we && 16'(fill_idx_q) == ctrl_i.z_height - 16'd1;
    assign z_valid    = state_q[st_ptr_q] == BANK_FULL && ctrl_i.ready;
    assign st_done    = z_valid && 16'(st_idx_q) == ctrl_i.z_width - 16'd1;
    for (genvar b = 0; b < NB; b++) begin : g_bank
        redmule_z_buffer_bank #(.D(D), .W(W), .BITW(BITW)) i_bank (
            .clk_i,
            .row_we    (fill_we && push_ptr_q == PA'(b)),
            .row_waddr (fill_idx_q),
            .row_wdata (z_buffer_i),
            .row_raddr (d_idx_q),
            .row_rdata (row_rdata[b]),
            .col_we    (ld_beat && ld_ptr_q == PA'(b)),
            .col_waddr (w_idx_q),
            .col_wdata (y_buffer_i),
            .col_raddr (st_idx_q),
            .col_rdata (col_rdata[b])
        );
    end
    // later events win: a bank finishing its fill while still LOADED goes straight to FULL
    always_comb begin
        for (int b = 0; b < NB; b++) state_d[b] = state_q[b];
        if (ld_done || byp_ld) state_d[ld_ptr_q] = BANK_LOADED;
        if (push_wrap) state_d[push_ptr_q] = BANK_FILLING;
        if (fill_done) state_d[push_ptr_q] = BANK_FULL;
        if (st_done) state_d[st_ptr_q] = BANK_FREE;
    end
    always_comb begin
        flags_o = '0;
        flags_o.y_ready = y_ready;
        flags_o.z_valid = z_valid;
        flags_o.z_priority = state_q[st_ptr_q] == BANK_FULL;
        flags_o.y_pushed = push_wrap;
        flags_o.loaded = state_q[push_ptr_q] == BANK_LOADED || ld_done || byp_ld;
        flags_o.empty = st_done || (push_wrap && ctrl_i.first_load);
        flags_o.fill_ready = fill_ready;
        for (int b = 0; b < NB; b++) flags_o.free_banks = flags_o.free_banks + 8'(state_q[b] == BANK_FREE);
    end
    for (genvar i = 0; i < D; i++) begin : g_strb
        assign z_strb_o[i*BITW/8 +: BITW/8] = {(BITW/8){16'(i) < ctrl_i.z_height}};
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NB; b++) state_q[b] <= BANK_FREE;
            {byp_q, ld_ptr_q, push_ptr_q, st_ptr_q} <= '0;
            {w_idx_q, st_idx_q, d_idx_q, fill_idx_q} <= '0;
            {y_buf_q, z_buf_q} <= '0;
        end else if (clear_i) begin
            for (int b = 0; b < NB; b++) state_q[b] <= BANK_FREE;
            {byp_q, ld_ptr_q, push_ptr_q, st_ptr_q} <= '0;
            {w_idx_q, st_idx_q, d_idx_q, fill_idx_q} <= '0;
            {y_buf_q, z_buf_q} <= '0;
        end else begin
            for (int b = 0; b < NB; b++) state_q[b] <= state_d[b];
            if (ld_done) byp_q[ld_ptr_q] <= 1'b0;
            if (byp_ld) byp_q[ld_ptr_q] <= 1'b1;
            if (ld_beat) w_idx_q <= ld_done ? '0 : w_idx_q + 1'b1;
            if (ld_done || byp_ld) ld_ptr_q <= ld_ptr_q + 1'b1;
            if (push) d_idx_q <= push_wrap ? '0 : d_idx_q + 1'b1;
            if (push) y_buf_q <= byp_q[push_ptr_q] ? '0 : row_rdata[push_ptr_q];
            if (fill_we) fill_idx_q <= fill_done ? '0 : fill_idx_q + 1'b1;
            if (fill_done) d_idx_q <= '0;
            if (fill_done) push_ptr_q <= push_ptr_q + 1'b1;
            if (z_valid) z_buf_q <= col_rdata[st_ptr_q];
            if (z_valid) st_idx_q <= st_done ? '0 : st_idx_q + 1'b1;
            if (st_done) st_ptr_q <= st_ptr_q + 1'b1;
        end
    end
    assign y_buffer_o = y_buf_q;
    assign z_buffer_o = z_buf_q;
    fill_protocol: assert property (@(posedge clk_i) disable iff (!rst_ni) ctrl_i.fill |-> fill_ready);
`ifdef REDMULE_ZBUF_PERF_CNT_EN
    logic any_full;
    logic [2:0] perf_inc;
    always_comb begin
        any_full = 1'b0;
        for (int b = 0; b < NB; b++) any_full = any_full || state_q[b] == BANK_FULL;
    end
    assign perf_inc = {byp_ld, z_valid, !fill_ready && any_full};
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) perf_o <= '0;
        else if (clear_i) perf_o <= '0;
        else for (int i = 0; i < 3; i++) if (perf_inc[i] && perf_o[i] != '1) perf_o[i] <= perf_o[i] + 1'b1;
    end
`endif
endmodule

// File: tb/tb_redmule_z_buffer_pp.sv
// tb_redmule_z_buffer_pp: directed lifecycle sequence with random data against a matrix reference model
module tb_redmule_z_buffer_pp;
    import redmule_z_buffer_pp_pkg::*;
    localparam int BITW = 16;
    localparam int W = ARRAY_WIDTH;
    localparam int DW = 288;
    localparam int D = DW / BITW;
    localparam int NB = 2;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic clear_i = 1'b0;
    z_buffer_pp_ctrl_t ctrl_i;
    logic [W*BITW-1:0] z_buffer_i, y_buffer_o;
    logic [DW-1:0] y_buffer_i, z_buffer_o;
    logic [DW/8-1:0] z_strb_o;
    z_buffer_pp_flgs_t flags_o;
    int checks = 0;
    int errors = 0;
    logic [15:0] ys [4][W][D];
    logic [15:0] zs [4][D][W];
    always #5 clk_i = ~clk_i;
    redmule_z_buffer_pp #(.DW(DW), .FpFormat(FP16), .Width(W), .NB(NB)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .ctrl_i(ctrl_i),
        .z_buffer_i(z_buffer_i), .y_buffer_i(y_buffer_i), .z_buffer_o(z_buffer_o),
        .y_buffer_o(y_buffer_o), .z_strb_o(z_strb_o), .flags_o(flags_o)
    );
    function automatic logic [DW-1:0] ycol(int s, int w);
        logic [DW-1:0] r = '0;
        for (int d = 0; d < D; d++) r[d*BITW +: BITW] = ys[s][w][d];
        return r;
    endfunction
    function automatic logic [DW-1:0] yrow(int s, int d, int nw);
        logic [DW-1:0] r = '0;
        for (int w = 0; w < nw; w++) r[w*BITW +: BITW] = ys[s][w][d];
        return r;
    endfunction
    function automatic logic [DW-1:0] zrow(int s, int d);
        logic [DW-1:0] r = '0;
        for (int w = 0; w < W; w++) r[w*BITW +: BITW] = zs[s][d][w];
        return r;
    endfunction
    function automatic logic [DW-1:0] zcol(int s, int c, int zh);
        logic [DW-1:0] r = '0;
        for (int d = 0; d < zh; d++) r[d*BITW +: BITW] = zs[s][d][c];
        return r;
    endfunction
    function automatic logic [DW-1:0] elmask(int n);
        logic [DW-1:0] r = '0;
        for (int i = 0; i < n; i++) r[i*BITW +: BITW] = '1;
        return r;
    endfunction
    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic load_bank(int s, int n);
        for (int w = 0; w < n; w++) begin
            @(negedge clk_i);
            ctrl_i.y_valid = 1'b1;
            y_buffer_i = ycol(s, w);
            #1;
            chk("load_y_ready", flags_o.y_ready, 1);
            chk("load_loaded", flags_o.loaded, w == n - 1);
            @(posedge clk_i); #1;
        end
        ctrl_i.y_valid = 1'b0;
    endtask
    task automatic push_bank(int s, int n, bit byp, bit fl, int nw);
        for (int d = 0; d < n; d++) begin
            @(negedge clk_i);
            ctrl_i.y_push_enable = 1'b1;
            ctrl_i.first_load = fl;
            #1;
            chk("push_y_pushed", flags_o.y_pushed, d == n - 1);
            chk("push_empty", flags_o.empty, fl && d == n - 1);
            @(posedge clk_i); #1;
            chk("push_y_data", y_buffer_o & elmask(nw), byp ? '0 : yrow(s, d, nw));
        end
        ctrl_i.y_push_enable = 1'b0;
        ctrl_i.first_load = 1'b0;
    endtask
    task automatic fill_bank(int s, int n);
        for (int d = 0; d < n; d++) begin
            @(negedge clk_i);
            ctrl_i.fill = 1'b1;
            z_buffer_i = zrow(s, d);
            #1;
            chk("fill_ready", flags_o.fill_ready, 1);
            @(posedge clk_i); #1;
        end
        ctrl_i.fill = 1'b0;
    endtask
    task automatic store_bank(int s, int n, int zh, int ls, int ln);
        for (int c = 0; c < n; c++) begin
            @(negedge clk_i);
            ctrl_i.ready = 1'b1;
            ctrl_i.y_valid = c < ln;
            if (c < ln) y_buffer_i = ycol(ls, c);
            #1;
            chk("store_z_valid", flags_o.z_valid, 1);
            chk("store_empty", flags_o.empty, c == n - 1);
            if (c < ln) chk("overlap_y_ready", flags_o.y_ready, 1);
            @(posedge clk_i); #1;
            chk("store_z_data", z_buffer_o & elmask(zh), zcol(s, c, zh));
        end
        ctrl_i.ready = 1'b0;
        ctrl_i.y_valid = 1'b0;
    endtask
    task automatic store_one_beat();
        @(negedge clk_i);
        ctrl_i.ready = 1'b1;
        #1;
        chk("mid_z_valid", flags_o.z_valid, 1);
        @(posedge clk_i); #1;
        chk("mid_z_data", z_buffer_o & elmask(1), zcol(0, 0, 1));
    endtask
    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end
    initial begin
        ctrl_i = '0;
        ctrl_i.y_width = 4; ctrl_i.y_height = 8; ctrl_i.z_width = 4; ctrl_i.z_height = 8;
        z_buffer_i = '0;
        y_buffer_i = '0;
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < D; a++)
                for (int b = 0; b < W; b++) begin
                    ys[s][b][a] = 16'($urandom);
                    zs[s][a][b] = 16'($urandom);
                end
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rst_z_valid", flags_o.z_valid, 0);
        chk("rst_fill_ready", flags_o.fill_ready, 0);
        chk("rst_free_banks", flags_o.free_banks, NB);
        chk("rst_loaded", flags_o.loaded, 0);
        chk("rst_empty", flags_o.empty, 0);
        chk("rst_z_priority", flags_o.z_priority, 0);
        chk("rst_y_buffer", y_buffer_o, 0);
        chk("rst_z_buffer", z_buffer_o, 0);
        chk("strb_h8", z_strb_o, 36'h0_0000_ffff);
        // full lifecycle on bank 0
        load_bank(0, 4);
        chk("after_load_free", flags_o.free_banks, 1);
        chk("after_load_loaded", flags_o.loaded, 1);
        push_bank(0, 8, 0, 0, 4);
        chk("after_push_loaded", flags_o.loaded, 0);
        chk("after_push_fill_ready", flags_o.fill_ready, 1);
        fill_bank(0, 8);
        chk("full_fill_ready", flags_o.fill_ready, 0);
        chk("full_z_priority", flags_o.z_priority, 1);
        chk("full_free", flags_o.free_banks, 1);
        // store bank 0 while bank 1 loads
        store_bank(0, 4, 8, 1, 4);
        chk("overlap_free", flags_o.free_banks, 1);
        chk("overlap_loaded", flags_o.loaded, 1);
        // bypass load of bank 0
        @(negedge clk_i);
        ctrl_i.y_bypass = 1'b1;
        #1;
        chk("byp_y_ready", flags_o.y_ready, 0);
        chk("byp_free_before", flags_o.free_banks, 1);
        @(posedge clk_i); #1;
        ctrl_i.y_bypass = 1'b0;
        chk("byp_free_after", flags_o.free_banks, 0);
        push_bank(1, 8, 0, 1, 4);
        fill_bank(1, 8);
        push_bank(0, 8, 1, 0, 4);
        fill_bank(2, 8);
        // back-pressure with both banks full
        #1;
        chk("bp_fill_ready", flags_o.fill_ready, 0);
        chk("bp_free", flags_o.free_banks, 0);
        chk("bp_z_valid", flags_o.z_valid, 0);
        chk("bp_z_priority", flags_o.z_priority, 1);
        chk("bp_y_ready", flags_o.y_ready, 0);
        store_bank(1, 4, 8, 0, 0);
        chk("bp_free_after_store", flags_o.free_banks, 1);
        store_bank(2, 4, 8, 0, 0);
        // single-beat edges
        ctrl_i.y_width = 1; ctrl_i.y_height = 1; ctrl_i.z_width = 1; ctrl_i.z_height = 1;
        #1;
        chk("strb_h1", z_strb_o, 36'h3);
        load_bank(3, 1);
        push_bank(3, 1, 0, 0, 1);
        fill_bank(3, 1);
        chk("edge_z_priority", flags_o.z_priority, 1);
        chk("edge_fill_ready", flags_o.fill_ready, 0);
        chk("edge_free", flags_o.free_banks, 1);
        store_bank(3, 1, 1, 0, 0);
        chk("edge_free_after", flags_o.free_banks, 2);
        // synchronous clear mid-store
        ctrl_i.z_width = 4;
        load_bank(0, 1);
        push_bank(0, 1, 0, 0, 1);
        fill_bank(0, 1);
        store_one_beat();
        @(negedge clk_i);
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        chk("clr_z_valid", flags_o.z_valid, 0);
        chk("clr_free", flags_o.free_banks, NB);
        chk("clr_z_buffer", z_buffer_o, 0);
        chk("clr_fill_ready", flags_o.fill_ready, 0);
        chk("clr_z_priority", flags_o.z_priority, 0);
        ctrl_i.ready = 1'b0;
        // asynchronous reset mid-store
        load_bank(0, 1);
        push_bank(0, 1, 0, 0, 1);
        fill_bank(0, 1);
        store_one_beat();
        rst_ni = 1'b0;
        #2;
        chk("arst_z_valid", flags_o.z_valid, 0);
        chk("arst_free", flags_o.free_banks, NB);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("arst_z_valid_next", flags_o.z_valid, 0);
        chk("arst_z_buffer", z_buffer_o, 0);
        chk("arst_y_buffer", y_buffer_o, 0);
        chk("arst_fill_ready", flags_o.fill_ready, 0);
        ctrl_i.ready = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/redmule_z_buffer_pp.md
Name: redmule_z_buffer_pp

Overview:
Multi-bank (ping-pong) successor of the RedMulE Z/Y accumulator buffer, placed between the streamer and the engine array.
- NB independent D x W banks, each with its own lifecycle, so bias (Y) loading, bias pushing/result filling, and Z store-out overlap across banks.
- Adds a bias-bypass mode: zero bias, no Y load phase.
- Adds explicit back-pressure on the fill path.

Parameters:
DW, 288, streamer data width in bits; multiple of BITW.
FpFormat, fpnew_pkg::FP16, element format; BITW = fpnew_pkg::fp_width(FpFormat).
Width, ARRAY_WIDTH, elements per array row (W).
NB, 2, bank count; power of two, >= 2.
D (localparam), DW/BITW, rows per bank.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear: all banks FREE, all counters and pointers 0
ctrl_i  in  z_buffer_pp_ctrl_t  fields: fill, y_valid, ready, y_push_enable, y_bypass, first_load, y_width, y_height, z_width, z_height
z_buffer_i  in  W*BITW  array output row, written on fill
y_buffer_i  in  DW  bias column from streamer
z_buffer_o  out  DW  Z column to streamer
y_buffer_o  out  W*BITW  bias row to array
z_strb_o  out  DW/8  byte strobes for z_buffer_o
flags_o  out  z_buffer_pp_flgs_t  fields: y_ready, z_valid, z_priority, y_pushed, loaded, empty, fill_ready, free_banks

Behaviour:
- Reset and clear: all banks FREE; ld_ptr = push_ptr = st_ptr = 0; all counters 0.
  - Outputs: flags all 0 except fill_ready = 0 and free_banks = NB; data outputs 0.
- Per-bank FSM: FREE -> LOADED -> FILLING -> FULL -> FREE.
- FREE -> LOADED
  - Bank[ld_ptr] accepts one Y column per cycle when y_valid & y_ready.
  - y_ready = bank[ld_ptr] FREE and no push in progress on that bank.
  - Column index w_idx increments per beat; LOADED when w_idx == y_width-1 on a beat. ld_ptr then advances mod NB.
  - y_bypass = 1: a FREE bank at ld_ptr goes directly to LOADED with zero contents. No y_ready beats issued; one cycle per bank.
- LOADED -> FILLING
  - Bank[push_ptr] drives row d_idx onto y_buffer_o, registered: data valid the cycle after y_push_enable.
  - d_idx wraps at y_height-1; y_pushed pulses on the wrapping cycle and the bank enters FILLING.
  - Bypass banks output zero.
- FILLING -> FULL
  - fill writes z_buffer_i into row fill_idx of bank[push_ptr].
  - FULL when fill_idx == z_height-1 on fill; push_ptr advances.
  - fill_ready = bank[push_ptr] in LOADED or FILLING.
  - fill while !fill_ready is a protocol error: write dropped, assertion fires.
- FULL -> FREE
  - Bank[st_ptr] presents column st_idx; z_valid = FULL & ready; z_priority = FULL.
  - z_buffer_o is registered: data valid the cycle after a z_valid handshake.
  - st_idx wraps at z_width-1; bank goes FREE and st_ptr advances.
  - empty pulses on that cycle, or when y_pushed coincides with first_load.
- loaded = bank[push_ptr] LOADED, or bank[ld_ptr] completing its load this cycle.
- Simultaneous events:
  - Load, push/fill and store on three distinct banks all proceed in the same cycle.
  - A bank freed by a store is not loadable until the next cycle.
  - Fill completion and push start on the next bank may coincide.
- z_strb_o: bytes [i*BITW/8 +: BITW/8] set for i < z_height, others 0.
- Counter widths: clog2(D) for d_idx/fill_idx, clog2(W) for w_idx/st_idx, clog2(NB) for pointers. Pointers wrap naturally.
- Asynchronous reset mid-operation discards all bank contents and returns to the reset state.

Optional Feature:
REDMULE_ZBUF_PERF_CNT_EN
- Defined: adds three 32-bit saturating counters, clear by clear_i, read on output perf_o (3x32): fill-stall cycles (fill_ready = 0 while a bank is FULL), store cycles, bypass banks.
- Undefined: perf_o absent, no counter logic.

Decomposition:
- redmule_pkg gains z_buffer_pp_ctrl_t, z_buffer_pp_flgs_t, the bank-state enum, and the ZBUF_NB_DEFAULT constant.
- Sub-module redmule_z_buffer_bank: one D x W SCM bank with row write/read and column write/read ports, instantiated NB times.
- Top-level block holds the FSMs, counters and pointers.

Test Plan:
- Load, y_width=4 / y_height=8 / z_height=8 / z_width=4: 4 Y beats -> loaded; 8 pushes -> y_pushed; 8 fills -> bank FULL; 4 stores -> empty pulse; z_buffer_o equals the filled rows transposed.
- Overlap, NB=2: bank0 storing while bank1 loads in the same cycles -> y_ready and z_valid both 1; no data corruption.
- Bypass, y_bypass=1: y_ready never asserted; y_buffer_o = 0 for all 8 pushes; stored result equals the fill data.
- Back-pressure: both banks FULL, ready=0 -> fill_ready=0, free_banks=0; one store completion -> free_banks=1 next cycle.
- Edges: z_height=1 and y_width=1 single-beat transitions -> FULL after 1 fill; z_strb_o = 0x0003 for FP16.
- Reset/clear mid-store -> state FREE, free_banks=NB, z_valid=0 the next cycle.
